rst_sequencer: RTL and testbench

- Reset sequencer placed directly downstream of the global clock buffer (BUFG, PH1 build).
- Clocked by the buffered clock. Synchronises the asynchronous PLL lock flag and filters it for stability.
- Holds the downstream reset (TEMAC/filter datapath) for a programmable number of cycles, then releases it.
- Re-asserts reset on loss of lock or on a soft-reset request.

---
 rtl/rst_sequencer_if.sv | 11 +
 rtl/rst_sequencer.sv | 76 +++++++
 tb/tb_rst_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock/soft-reset inputs and reset/status outputs of the sequencer
interface rst_sequencer_if;
  logic       LOCKED;
  logic       SOFT_RST;
  logic       RST_OUT;
  logic       RST_N_OUT;
  logic       READY;
  logic [1:0] STATE;
  modport master (output LOCKED, SOFT_RST, input RST_OUT, RST_N_OUT, READY, STATE);
  modport slave (input LOCKED, SOFT_RST, output RST_OUT, RST_N_OUT, READY, STATE);
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: synchronises and filters PLL lock, then holds and releases downstream reset
module rst_sequencer #(
  parameter int SYNC_STAGES = 3,
  parameter int LOCK_FILT   = 8,
  parameter int HOLD_CYCLES = 64,
  parameter int CNT_W       = 16
) (
  input logic           C,
  input logic           R,
  rst_sequencer_if.slave io
);
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, FILTER = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  state_t                 state_q = WAIT_LOCK;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q = '0;
  logic [CNT_W-1:0]       cnt_d;
  logic [SYNC_STAGES-1:0] sync_q = '0;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rst_out_q = 1'b1;
  logic                   rst_n_out_q = 1'b0;
  logic                   ready_q = 1'b0;
  logic                   rst_out_d, rst_n_out_d, ready_d;
  logic                   lock_s;
  assign lock_s = sync_q[SYNC_STAGES-1];
  // next-state decode: lock loss beats soft reset beats counter terminal
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], io.LOCKED};
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        state_d = lock_s ? FILTER : WAIT_LOCK;
        cnt_d = '0;
      end
      FILTER: begin
        state_d = !lock_s ? WAIT_LOCK : (cnt_q == FILT_END) ? HOLD : FILTER;
        cnt_d = (!lock_s || cnt_q == FILT_END) ? '0 : cnt_q + CNT_W'(1);
      end
      HOLD: begin
        state_d = !lock_s ? WAIT_LOCK : io.SOFT_RST ? HOLD : (cnt_q == HOLD_END) ? RUN : HOLD;
        cnt_d = (!lock_s || io.SOFT_RST || cnt_q == HOLD_END) ? '0 : cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = !lock_s ? WAIT_LOCK : io.SOFT_RST ? HOLD : RUN;
        cnt_d = '0;
      end
    endcase
    rst_out_d = state_d != RUN;
    rst_n_out_d = state_d == RUN;
    ready_d = state_d == RUN;
  end
  // state, counter, synchroniser and outputs all load on the same edge
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      sync_q <= '0;
      rst_out_q <= 1'b1;
      rst_n_out_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      rst_out_q <= rst_out_d;
      rst_n_out_q <= rst_n_out_d;
      ready_q <= ready_d;
    end
  end
  assign io.RST_OUT = rst_out_q;
  assign io.RST_N_OUT = rst_n_out_q;
  assign io.READY = ready_q;
  assign io.STATE = state_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed checks of reset sequencing, lock loss, soft reset and R priority
module tb_rst_sequencer;
  logic C = 1'b0;
  logic R = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  rst_sequencer_if io();
  rst_sequencer dut (.C(C), .R(R), .io(io));
  always #5 C = ~C;
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge C);
    #1;
  endtask
  task automatic expect_st(input string tag, input int k, input int st);
    chk($sformatf("%s.state@%0d", tag, k), int'(io.STATE), st);
    chk($sformatf("%s.rst@%0d", tag, k), int'(io.RST_OUT), int'(st != 3));
    chk($sformatf("%s.rst_n@%0d", tag, k), int'(io.RST_N_OUT), int'(st == 3));
    chk($sformatf("%s.ready@%0d", tag, k), int'(io.READY), int'(st == 3));
  endtask
  function automatic int seq_state(input int k);
    return (k < 4) ? 0 : (k < 12) ? 1 : (k < 76) ? 2 : 3;
  endfunction
  initial begin
    io.LOCKED = 1'b1;
    io.SOFT_RST = 1'b0;
    repeat (5) tick();
    expect_st("reset", 0, 0);
    R = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      expect_st("powerup", k, seq_state(k));
    end
    R = 1'b1;
    tick();
    R = 1'b0;
    for (int k = 1; k <= 85; k++) begin
      io.LOCKED = (k != 7);
      tick();
      expect_st("glitch", k, (k < 10) ? seq_state(k) : (k == 10) ? 0 : seq_state(k - 7));
    end
    io.LOCKED = 1'b1;
    for (int j = 1; j <= 66; j++) begin
      io.SOFT_RST = (j == 1);
      tick();
      expect_st("soft1", j, (j <= 64) ? 2 : 3);
    end
    for (int j = 1; j <= 95; j++) begin
      io.SOFT_RST = (j == 1 || j == 30);
      tick();
      expect_st("soft2", j, (j < 94) ? 2 : 3);
    end
    for (int j = 1; j <= 100; j++) begin
      io.SOFT_RST = 1'b1;
      tick();
      expect_st("softheld", j, 2);
    end
    for (int j = 1; j <= 65; j++) begin
      io.SOFT_RST = 1'b0;
      tick();
      expect_st("softrel", j, (j < 64) ? 2 : 3);
    end
    for (int j = 1; j <= 5; j++) begin
      io.LOCKED = 1'b0;
      tick();
      expect_st("lockloss", j, (j < 4) ? 3 : 0);
    end
    for (int k = 1; k <= 24; k++) begin
      io.LOCKED = (k <= 20);
      io.SOFT_RST = (k == 24);
      tick();
      expect_st("lockvsoft", k, (k <= 20) ? seq_state(k) : (k < 24) ? 2 : 0);
    end
    for (int k = 1; k <= 80; k++) begin
      io.LOCKED = 1'b1;
      io.SOFT_RST = (k <= 12);
      tick();
      expect_st("softignored", k, seq_state(k));
    end
    io.SOFT_RST = 1'b0;
    R = 1'b1;
    tick();
    R = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      tick();
      expect_st("prehold", k, seq_state(k));
    end
    R = 1'b1;
    tick();
    expect_st("rpulse", 43, 0);
    R = 1'b0;
    for (int k = 1; k <= 77; k++) begin
      tick();
      expect_st("afterr", k, seq_state(k));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
